// File: rtl/writeback_unit_pkg.sv
// Shared constants, load-type encodings and the load-buffer entry record for the writeback unit.
package writeback_unit_pkg;

  localparam int unsigned XlenDefault = 64;
  // Buffer entries are sized for the widest supported XLEN; narrower builds use the low bits.
  localparam int unsigned XlenMax = 64;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Ld  = 3'b011;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Lwu = 3'b110;

  typedef struct packed {
    logic [4:0]         rd;
    logic [XlenMax-1:0] data;
    logic               wen;
  } wb_entry_t;

  function automatic logic [XlenMax-1:0] load_extend(input logic [XlenMax-1:0] data,
                                                     input logic [2:0]         funct3);
    logic [XlenMax-1:0] res;
    case (funct3)
      Funct3Lb:  res = {{(XlenMax - 8){data[7]}}, data[7:0]};
      Funct3Lh:  res = {{(XlenMax - 16){data[15]}}, data[15:0]};
      Funct3Lw:  res = {{(XlenMax - 32){data[31]}}, data[31:0]};
      Funct3Lbu: res = {{(XlenMax - 8){1'b0}}, data[7:0]};
      Funct3Lhu: res = {{(XlenMax - 16){1'b0}}, data[15:0]};
      Funct3Lwu: res = {{(XlenMax - 32){1'b0}}, data[31:0]};
      default:   res = data;  // LD and unused encodings pass through
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Circular load-result buffer with squash-by-destination support.
module wb_load_fifo
  import writeback_unit_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  input  logic      squash,
  input  logic [4:0] squash_rd,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t        mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Squash first so a same-cycle push keeps its own write-enable.
      if (squash) begin
        for (int i = 0; i < Depth; i++) begin
          if (mem_q[i].rd == squash_rd) mem_q[i].wen <= 1'b0;
        end
      end
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter between ALU results and buffered load responses.
// Define WB_LOAD_EXT_EN to sign/zero-extend load data according to ld_funct3.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XlenDefault,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic            alu_wen,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] writeData,
  output logic            regWrite,
  output logic            stall,
  output logic            ld_pending
);

  logic            init_q;
  logic            full, empty;
  logic            alu_fire, ld_fire, cut, pop, push;
  logic [XLEN-1:0] ld_ext;
  wb_entry_t       head, push_entry;
  logic            regwrite_d, regwrite_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] wdata_d, wdata_q;

`ifdef WB_LOAD_EXT_EN
  assign ld_ext = XLEN'(load_extend(XlenMax'(ld_data), ld_funct3));
`else
  logic unused_funct3;
  assign unused_funct3 = ^ld_funct3;
  assign ld_ext        = ld_data;
`endif

  assign stall      = full;
  assign ld_ready   = ~full;
  assign ld_pending = ~empty;

  // init_q holds off all writes until the second edge after reset release.
  assign ld_fire  = ld_valid & ~full;
  assign alu_fire = init_q & ~full & alu_valid & alu_wen & (alu_rd != 5'd0);
  assign pop      = ~empty & (full | ~alu_fire);
  assign cut      = init_q & ~full & ~alu_fire & empty & ld_fire;
  assign push     = ld_fire & ~cut;

  always_comb begin
    push_entry      = '0;
    push_entry.rd   = ld_rd;
    push_entry.data = XlenMax'(ld_ext);
    push_entry.wen  = (ld_rd != 5'd0) & ~(alu_fire & (alu_rd == ld_rd));
  end

  wb_load_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .squash    (alu_fire),
    .squash_rd (alu_rd),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = '0;
    wdata_d    = '0;
    if (pop) begin
      regwrite_d = head.wen;
      rd_d       = head.rd;
      wdata_d    = head.data[XLEN-1:0];
    end else if (alu_fire) begin
      regwrite_d = 1'b1;
      rd_d       = alu_rd;
      wdata_d    = alu_result;
    end else if (cut) begin
      regwrite_d = (ld_rd != 5'd0);
      rd_d       = ld_rd;
      wdata_d    = ld_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_q     <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      init_q     <= 1'b1;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign regWrite  = regwrite_q;
  assign rd        = rd_q;
  assign writeData = wdata_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_writeback_unit;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            alu_valid = 1'b0, alu_wen = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_result = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [4:0]      ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic [2:0]      ld_funct3 = '0;
  logic [4:0]      rd;
  logic [XLEN-1:0] writeData;
  logic            regWrite, stall, ld_pending;

  writeback_unit #(
    .XLEN      (XLEN),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_wen   (alu_wen),
    .alu_rd    (alu_rd),
    .alu_result(alu_result),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_funct3 (ld_funct3),
    .rd        (rd),
    .writeData (writeData),
    .regWrite  (regWrite),
    .stall     (stall),
    .ld_pending(ld_pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Sign/zero extension by arithmetic on the low n bits.
  function automatic logic [63:0] low_bits(input logic [63:0] d, input int n, input bit sgn);
    logic [63:0] lo;
    lo = d & ((64'd1 << n) - 64'd1);
    if (sgn && lo >= (64'd1 << (n - 1))) lo = lo - (64'd1 << n);
    return lo;
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] d, input logic [2:0] f3);
`ifdef WB_LOAD_EXT_EN
    case (f3)
      3'd0: return low_bits(d, 8, 1'b1);
      3'd1: return low_bits(d, 16, 1'b1);
      3'd2: return low_bits(d, 32, 1'b1);
      3'd4: return low_bits(d, 8, 1'b0);
      3'd5: return low_bits(d, 16, 1'b0);
      3'd6: return low_bits(d, 32, 1'b0);
      default: return d;
    endcase
`else
    return (f3 == 3'd7) ? d : d;
`endif
  endfunction

  // Reference model: a queue of pending loads plus the expected registered write.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          wen;
  } ment_t;

  ment_t       mq[$];
  bit          m_armed = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_wd = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_armed = 1'b0;
      m_we = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin : model_step
      bit    m_full, acc, alu_w;
      ment_t e;
      m_full = (mq.size() == DEPTH);
      acc    = ld_valid && !m_full;
      alu_w  = m_armed && !m_full && alu_valid && alu_wen && (alu_rd != 5'd0);
      m_we = 1'b0;
      m_rd = '0;
      m_wd = '0;
      if (mq.size() > 0 && (m_full || !alu_w)) begin
        e = mq.pop_front();
        m_we = e.wen;
        m_rd = e.rd;
        m_wd = e.data;
      end else if (alu_w) begin
        m_we = 1'b1;
        m_rd = alu_rd;
        m_wd = alu_result;
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].wen = 1'b0;
      end else if (acc && m_armed) begin
        m_we = (ld_rd != 5'd0);
        m_rd = ld_rd;
        m_wd = ext(ld_data, ld_funct3);
        acc  = 1'b0;
      end
      if (acc) begin
        mq.push_back('{ld_rd, ext(ld_data, ld_funct3),
                       (ld_rd != 5'd0) && !(alu_w && alu_rd == ld_rd)});
      end
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m_regWrite", regWrite, m_we);
    if (m_we) begin
      chk("m_rd", rd, m_rd);
      chk("m_writeData", writeData, m_wd);
    end
    chk("m_stall", stall, mq.size() == DEPTH);
    chk("m_ld_ready", ld_ready, mq.size() != DEPTH);
    chk("m_ld_pending", ld_pending, mq.size() != 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_wen   = 1'b0;
    alu_rd    = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_funct3 = '0;
  endtask

  task automatic alu(input logic [4:0] r, input logic [63:0] v);
    alu_valid = 1'b1;
    alu_wen = 1'b1;
    alu_rd = r;
    alu_result = v;
  endtask

  task automatic ld(input logic [4:0] r, input logic [63:0] v, input logic [2:0] f3);
    ld_valid = 1'b1;
    ld_rd = r;
    ld_data = v;
    ld_funct3 = f3;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #3;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_rd", rd, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ld_pending", ld_pending, 0);
    chk("rst_ld_ready", ld_ready, 1);
    step();
    step();
    // No write on the first edge after release, even with an ALU result present
    reset = 1'b1;
    alu(5'd6, 64'h66);
    step();
    chk("first_edge_regWrite", regWrite, 0);
    step();
    chk("second_edge_regWrite", regWrite, 1);
    chk("second_edge_rd", rd, 6);

    // ALU write, then write to x0
    alu(5'd5, 64'h1234);
    step();
    chk("alu_regWrite", regWrite, 1);
    chk("alu_rd", rd, 5);
    chk("alu_data", writeData, 64'h1234);
    alu_rd = 5'd0;
    step();
    chk("alu_x0_regWrite", regWrite, 0);
    idle();

    // Cut-through LB / LBU
    ld(5'd7, 64'h80, 3'b000);
    step();
    chk("lb_regWrite", regWrite, 1);
    chk("lb_rd", rd, 7);
`ifdef WB_LOAD_EXT_EN
    chk("lb_data", writeData, 64'hFFFF_FFFF_FFFF_FF80);
`else
    chk("lb_data", writeData, 64'h80);
`endif
    ld_funct3 = 3'b100;
    step();
    chk("lbu_data", writeData, 64'h80);
    idle();
    step();

    // ALU and load in the same cycle
    alu(5'd3, 64'h33);
    ld(5'd4, 64'h44, 3'b011);
    step();
    chk("same_rd1", rd, 3);
    chk("same_pending1", ld_pending, 1);
    idle();
    step();
    chk("same_rd2", rd, 4);
    chk("same_data2", writeData, 64'h44);
    chk("same_pending2", ld_pending, 0);

    // Two loads buffered behind two ALU writes
    alu(5'd10, 64'h1);
    ld(5'd11, 64'h11, 3'b011);
    step();
    alu(5'd12, 64'h2);
    ld(5'd13, 64'h13, 3'b011);
    step();
    chk("full_stall", stall, 1);
    chk("full_ld_ready", ld_ready, 0);
    chk("full_rd", rd, 12);
    ld_valid = 1'b0;
    alu_wen = 1'b0;
    step();
    chk("drain1_rd", rd, 11);
    chk("drain1_data", writeData, 64'h11);
    chk("drain1_stall", stall, 0);
    step();
    chk("drain2_rd", rd, 13);
    chk("drain2_regWrite", regWrite, 1);
    chk("drain2_pending", ld_pending, 0);
    idle();

    // Write-after-write squash
    alu(5'd20, 64'h20);
    ld(5'd9, 64'hAA, 3'b011);
    step();
    idle();
    alu(5'd9, 64'h55);
    step();
    chk("waw_rd", rd, 9);
    chk("waw_data", writeData, 64'h55);
    idle();
    step();
    chk("waw_squash_regWrite", regWrite, 0);
    chk("waw_pending", ld_pending, 0);

    // Reset with two buffered entries
    alu(5'd1, 64'h1);
    ld(5'd2, 64'h2, 3'b011);
    step();
    alu(5'd3, 64'h3);
    ld(5'd4, 64'h4, 3'b011);
    step();
    idle();
    reset = 1'b0;
    #1;
    chk("mid_rst_regWrite", regWrite, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_ld_ready", ld_ready, 1);
    chk("mid_rst_pending", ld_pending, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_regWrite1", regWrite, 0);
    step();
    chk("post_rst_regWrite2", regWrite, 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(299) == 0) begin
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
      end else begin
        alu_valid  = 1'($urandom_range(1));
        alu_wen    = ($urandom_range(9) != 0);
        alu_rd     = 5'($urandom_range(7));
        alu_result = {$urandom, $urandom};
        ld_valid   = 1'($urandom_range(1));
        ld_rd      = 5'($urandom_range(7));
        ld_data    = {$urandom, $urandom};
        ld_funct3  = 3'($urandom_range(6));
        if (alu_valid && ld_valid && ld_rd == alu_rd) ld_rd = ld_rd ^ 5'd8;
        step();
      end
    end
    idle();
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
